// File: rtl/paint_pkg.sv
// paint_pkg
// Shared definitions for the framebuffer painting blocks: the reader/writer
// state encoding and the default geometry and colour widths, which keep the
// square writer and reader agreeing on the layout of a pixel.
// No ports; import with "import paint_pkg::*;".
package paint_pkg;

   localparam int COLOR_W_DEF = 3;
   localparam int SIZE_W_DEF  = 4;
   localparam int COORD_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      DRAIN = 2'd2
   } state_t;

endpackage

// File: rtl/read_square_if.sv
// read_square_if
// Bundles the two data paths of the square reader: the framebuffer read port
// (mem_rd/mem_x/mem_y out, mem_color back one cycle later) and the pixel
// output stream (out_valid/out_ready handshake with out_dx/out_dy/out_color).
// Modports:
//   master - the reader: drives read requests and the output stream
//   slave  - the environment: framebuffer and pixel consumer
interface read_square_if import paint_pkg::*; #(
   parameter int COLOR_W = COLOR_W_DEF,
   parameter int SIZE_W  = SIZE_W_DEF,
   parameter int COORD_W = COORD_W_DEF
);

   logic               mem_rd;
   logic [COORD_W-1:0] mem_x;
   logic [COORD_W-1:0] mem_y;
   logic [COLOR_W-1:0] mem_color;
   logic               out_valid;
   logic               out_ready;
   logic [SIZE_W-1:0]  out_dx;
   logic [SIZE_W-1:0]  out_dy;
   logic [COLOR_W-1:0] out_color;

   modport master (
      output mem_rd, mem_x, mem_y,
      input  mem_color,
      output out_valid, out_dx, out_dy, out_color,
      input  out_ready
   );

   modport slave (
      input  mem_rd, mem_x, mem_y,
      output mem_color,
      input  out_valid, out_dx, out_dy, out_color,
      output out_ready
   );

endinterface

// File: rtl/pixel_fifo2.sv
// pixel_fifo2
// Two-entry FIFO holding returned pixels ({dx, dy, colour}) until the
// consumer accepts them. The head entry is presented combinationally.
// Ports:
//   clk, resetn      clock and synchronous active-low reset
//   push, push_data  write one entry (caller guarantees it is not full)
//   pop              remove the head entry (caller guarantees not empty)
//   head             current head entry
//   count            number of stored entries, 0..2
module pixel_fifo2 #(
   parameter int WIDTH = 11
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic [1:0]       count
);

   logic [WIDTH-1:0] mem_q [2];
   logic [WIDTH-1:0] mem_d [2];
   logic             wr_q, wr_d;
   logic             rd_q, rd_d;
   logic [1:0]       count_q, count_d;

   // A push and a pop in the same cycle leave the count unchanged; the two
   // single-bit pointers simply toggle between the two slots.
   always_comb begin
      mem_d   = mem_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      count_d = count_q + {1'b0, push} - {1'b0, pop};
      if (push) begin
         mem_d[wr_q] = push_data;
         wr_d        = ~wr_q;
      end
      if (pop) begin
         rd_d = ~rd_q;
      end
   end

   // Storage is cleared on reset so the head reads as zero afterwards.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_q     <= 1'b0;
         rd_q     <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         mem_q   <= mem_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
      end
   end

   assign head  = mem_q[rd_q];
   assign count = count_q;

endmodule

// File: rtl/read_square.sv
// read_square
// Reads a (S_X+1) x (S_Y+1) pixel region back from the framebuffer, x
// counting down in the outer loop and y counting down in the inner loop,
// and streams each pixel's offset and colour over a valid/ready handshake.
// The sweep order matches the square writer so a copy engine can pair the
// two streams pixel-for-pixel.
// Ports:
//   clk, resetn   clock and synchronous active-low reset
//   start         request a read (only looked at while idle)
//   X, Y          region origin; S_X, S_Y region extent minus one
//   bus           read_square_if.master: framebuffer read port + pixel stream
//   busy          a read is in progress
//   done          one-cycle pulse after the last pixel is accepted
//   checksum      16-bit wrapping sum of accepted colours
// Optional feature: define READ_SQUARE_CHECKSUM_EN to build the checksum
// accumulator; otherwise checksum is tied to zero.
module read_square import paint_pkg::*; #(
   parameter int COLOR_W = COLOR_W_DEF,
   parameter int SIZE_W  = SIZE_W_DEF,
   parameter int COORD_W = COORD_W_DEF
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               start,
   input  logic [COORD_W-1:0] X,
   input  logic [COORD_W-1:0] Y,
   input  logic [SIZE_W-1:0]  S_X,
   input  logic [SIZE_W-1:0]  S_Y,
   read_square_if.master      bus,
   output logic               busy,
   output logic               done,
   output logic [15:0]        checksum
);

   localparam int ENTRY_W = 2*SIZE_W + COLOR_W;
   localparam logic [SIZE_W-1:0] ONE = SIZE_W'(1);

   state_t                state_q, state_d;
   logic [COORD_W-1:0]    x_q, x_d, y_q, y_d;
   logic [SIZE_W-1:0]     sy_q, sy_d;
   logic [SIZE_W-1:0]     xcnt_q, xcnt_d, ycnt_q, ycnt_d;
   logic [2*SIZE_W-1:0]   tag_q, tag_d;
   logic                  inflight_q, inflight_d;

   logic [1:0]            fifo_count;
   logic [ENTRY_W-1:0]    fifo_head;
   logic                  pop;
   logic                  mem_rd;
   logic [2:0]            occupancy;

   // The read issued last cycle returns now and goes straight into the FIFO.
   pixel_fifo2 #(.WIDTH(ENTRY_W)) u_fifo (
      .clk       (clk),
      .resetn    (resetn),
      .push      (inflight_q),
      .push_data ({tag_q, bus.mem_color}),
      .pop       (pop),
      .head      (fifo_head),
      .count     (fifo_count)
   );

   // A new read may only be issued if its pixel is guaranteed a FIFO slot
   // when it returns: stored pixels plus the one in flight, less the one
   // leaving this cycle, must be below the FIFO depth.
   always_comb begin
      occupancy = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
      mem_rd    = (state_q == SCAN) && (occupancy < 3'd2);
   end

   // Next-state logic: latch the request in IDLE, walk the region in SCAN,
   // and in DRAIN wait for the last pixel to leave before pulsing done.
   always_comb begin
      state_d    = state_q;
      x_d        = x_q;
      y_d        = y_q;
      sy_d       = sy_q;
      xcnt_d     = xcnt_q;
      ycnt_d     = ycnt_q;
      tag_d      = tag_q;
      inflight_d = mem_rd;
      done       = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               x_d     = X;
               y_d     = Y;
               sy_d    = S_Y;
               xcnt_d  = S_X;
               ycnt_d  = S_Y;
               state_d = SCAN;
            end
         end
         SCAN: begin
            if (mem_rd) begin
               tag_d = {xcnt_q, ycnt_q};
               if (ycnt_q == '0) begin
                  ycnt_d = sy_q;
                  xcnt_d = xcnt_q - ONE;
                  if (xcnt_q == '0) begin
                     state_d = DRAIN;
                  end
               end else begin
                  ycnt_d = ycnt_q - ONE;
               end
            end
         end
         DRAIN: begin
            if ((fifo_count == 2'd0) && !inflight_q) begin
               done    = 1'b1;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Reset discards any in-flight read along with the FIFO contents.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q    <= IDLE;
         x_q        <= '0;
         y_q        <= '0;
         sy_q       <= '0;
         xcnt_q     <= '0;
         ycnt_q     <= '0;
         tag_q      <= '0;
         inflight_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         x_q        <= x_d;
         y_q        <= y_d;
         sy_q       <= sy_d;
         xcnt_q     <= xcnt_d;
         ycnt_q     <= ycnt_d;
         tag_q      <= tag_d;
         inflight_q <= inflight_d;
      end
   end

   // Addresses and pixel fields read as zero whenever they are not valid,
   // so the idle/reset bus is quiet. Coordinate sums wrap without clipping.
   assign bus.mem_rd    = mem_rd;
   assign bus.mem_x     = mem_rd ? x_q + COORD_W'(xcnt_q) : '0;
   assign bus.mem_y     = mem_rd ? y_q + COORD_W'(ycnt_q) : '0;
   assign bus.out_valid = (fifo_count != 2'd0);
   assign pop           = bus.out_valid && bus.out_ready;
   assign bus.out_dx    = bus.out_valid ? fifo_head[ENTRY_W-1 -: SIZE_W] : '0;
   assign bus.out_dy    = bus.out_valid ? fifo_head[COLOR_W +: SIZE_W] : '0;
   assign bus.out_color = bus.out_valid ? fifo_head[COLOR_W-1:0] : '0;
   assign busy          = (state_q != IDLE) && !done;

`ifdef READ_SQUARE_CHECKSUM_EN
   logic [15:0] checksum_q, checksum_d;

   // Sum restarts when a new request is accepted and holds after done.
   always_comb begin
      checksum_d = checksum_q;
      if ((state_q == IDLE) && start) begin
         checksum_d = '0;
      end else if (pop) begin
         checksum_d = checksum_q + 16'(bus.out_color);
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         checksum_q <= '0;
      end else begin
         checksum_q <= checksum_d;
      end
   end

   assign checksum = checksum_q;
`else
   assign checksum = '0;
`endif

endmodule
